// File: rtl/v_change_reporter_if.sv
// Byte stream from the change reporter to the UART TX framer.
// A byte moves on every cycle where tx_valid and tx_ready are both high.
interface v_change_reporter_if;
   logic       tx_valid;
   logic       tx_ready;
   logic [7:0] tx_byte;
   logic       tx_first;
   logic       tx_last;

   modport master (
      output tx_valid,
      output tx_byte,
      output tx_first,
      output tx_last,
      input  tx_ready
   );

   modport slave (
      input  tx_valid,
      input  tx_byte,
      input  tx_first,
      input  tx_last,
      output tx_ready
   );
endinterface

// File: rtl/v_change_reporter.sv
// Watches NUM_CHANNELS virtual output buses and streams one chunk (type byte plus
// payload bytes MSB-first) for every channel whose value moved since it was last sent.
module v_change_reporter #(
   parameter int NUM_CHANNELS    = 4,
   parameter int DATA_WIDTH      = 16,
   parameter int CHUNK_TYPE_BASE = 2,
   parameter int HOLDOFF_CYCLES  = 0
) (
   input  logic                               CLK,
   input  logic                               reset,
   input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] ch_data,
   input  logic                               force_refresh,
   v_change_reporter_if.master                tx,
   output logic [NUM_CHANNELS-1:0]            pending
);
   localparam int NB      = DATA_WIDTH / 8;
   localparam int FRAME_W = 8 * (NB + 1);
   localparam int PTR_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
   localparam int K_W     = $clog2(NB + 1);
   localparam int HO_W    = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      HOLDOFF
   } state_t;

   state_t                  state_q, state_d;
   logic [DATA_WIDTH-1:0]   shadow_q [NUM_CHANNELS];
   logic [DATA_WIDTH-1:0]   shadow_d [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] pending_q, pending_d;
   logic [PTR_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [FRAME_W-1:0]      frame_q, frame_d;
   logic [K_W-1:0]          k_q, k_d;
   logic [HO_W-1:0]         ho_cnt_q, ho_cnt_d;

   logic [DATA_WIDTH-1:0]   ch_word [NUM_CHANNELS];
   logic [NUM_CHANNELS-1:0] differs;
   logic [NUM_CHANNELS-1:0] capture_vec;
   logic                    capture;
   logic                    xfer;
   logic [PTR_W-1:0]        sel;

   assign capture = (state_q == IDLE) && (|pending_q);
   assign xfer    = (state_q == SEND) && tx.tx_ready;

   for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_chan
      assign ch_word[gi]     = ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign differs[gi]     = (ch_word[gi] != shadow_q[gi]);
      assign capture_vec[gi] = capture && (sel == PTR_W'(gi));
   end

   // Scan from the farthest offset down so the nearest pending channel after rr_ptr wins.
   always_comb begin
      logic [PTR_W:0] idx;
      sel = '0;
      idx = '0;
      for (int off = NUM_CHANNELS; off >= 1; off--) begin
         idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(off);
         if (idx >= (PTR_W+1)'(NUM_CHANNELS)) begin
            idx = idx - (PTR_W+1)'(NUM_CHANNELS);
         end
         if (pending_q[idx[PTR_W-1:0]]) begin
            sel = idx[PTR_W-1:0];
         end
      end
   end

   // A capture and force_refresh on the same edge must leave the bit set.
   always_comb begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
         shadow_d[i]  = shadow_q[i];
         pending_d[i] = pending_q[i];
         if (capture_vec[i]) begin
            shadow_d[i]  = ch_word[i];
            pending_d[i] = 1'b0;
         end else if (differs[i]) begin
            pending_d[i] = 1'b1;
         end
         if (force_refresh) begin
            pending_d[i] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      frame_d  = frame_q;
      k_d      = k_q;
      ho_cnt_d = ho_cnt_q;
      case (state_q)
         IDLE: begin
            if (capture) begin
               frame_d  = {8'(CHUNK_TYPE_BASE) + 8'(sel), ch_word[sel]};
               rr_ptr_d = sel;
               k_d      = '0;
               state_d  = SEND;
            end
         end
         SEND: begin
            if (xfer) begin
               if (k_q == K_W'(NB)) begin
                  k_d = '0;
                  if (HOLDOFF_CYCLES > 0) begin
                     state_d  = HOLDOFF;
                     ho_cnt_d = HO_W'(HOLDOFF_CYCLES - 1);
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  k_d     = k_q + K_W'(1);
                  frame_d = frame_q << 8;
               end
            end
         end
         HOLDOFF: begin
            if (ho_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               ho_cnt_d = ho_cnt_q - HO_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (reset) begin
         state_q   <= IDLE;
         pending_q <= '1;
         rr_ptr_q  <= PTR_W'(NUM_CHANNELS - 1);
         frame_q   <= '0;
         k_q       <= '0;
         ho_cnt_q  <= '0;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         rr_ptr_q  <= rr_ptr_d;
         frame_q   <= frame_d;
         k_q       <= k_d;
         ho_cnt_q  <= ho_cnt_d;
         for (int i = 0; i < NUM_CHANNELS; i++) begin
            shadow_q[i] <= shadow_d[i];
         end
      end
   end

   assign tx.tx_valid = (state_q == SEND);
   assign tx.tx_byte  = (state_q == SEND) ? frame_q[FRAME_W-1 -: 8] : 8'h00;
   assign tx.tx_first = (state_q == SEND) && (k_q == '0);
   assign tx.tx_last  = (state_q == SEND) && (k_q == K_W'(NB));
   assign pending     = pending_q;
endmodule

// File: doc/v_change_reporter.md
Name: v_change_reporter

Overview:
- Parametrised successor of the single-channel virtual-LED change notifier.
- Watches NUM_CHANNELS virtual output buses of DATA_WIDTH bits each and flags any channel whose value differs from the last value it sent.
- Arbitrates pending channels round-robin and serialises one chunk at a time: one type byte, then the payload bytes MSB-first. The chunk is presented on a valid/ready byte stream that feeds the UART TX framer.
- Adds the things the old block lacked: multiple channels, multi-byte payloads, backpressure, forced refresh and a rate-limit holdoff.

Parameters:
- NUM_CHANNELS, 4: number of watched channels; legal range 1..16.
- DATA_WIDTH, 16: bits per channel; must be a multiple of 8 and at least 8. NB = DATA_WIDTH/8 payload bytes.
- CHUNK_TYPE_BASE, 2: channel i is sent with type byte CHUNK_TYPE_BASE+i; CHUNK_TYPE_BASE+NUM_CHANNELS-1 must be ≤ 255.
- HOLDOFF_CYCLES, 0: idle cycles enforced after each chunk before the next arbitration; 0 disables the holdoff.

Ports:
- CLK  in  1  clock.
- reset  in  1  synchronous, active-high.
- ch_data  in  NUM_CHANNELS*DATA_WIDTH  channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- force_refresh  in  1  one-cycle pulse that marks every channel pending.
- tx_valid  out  1  tx_byte is valid.
- tx_ready  in  1  consumer accepts the byte; a transfer happens when tx_valid && tx_ready.
- tx_byte  out  8  current stream byte.
- tx_first  out  1  high with the type byte.
- tx_last  out  1  high with the final payload byte.
- pending  out  NUM_CHANNELS  per-channel pending flags.

Behaviour:
- Reset values (applied at the edge where reset is sampled high):
  - shadow[i] = 0 for every channel.
  - pending = all ones, so every channel is reported once after reset.
  - rr_ptr = NUM_CHANNELS-1, so channel 0 wins first.
  - State = IDLE.
  - tx_valid, tx_first, tx_last = 0; tx_byte = 0.
- Reset mid-chunk aborts the chunk with no partial completion; tx_valid is low from the next cycle.
- Change detection, every edge, for each channel i:
  - If ch_data[i] != shadow[i] and channel i is not being captured this edge, set pending[i].
  - If force_refresh is high, set all pending bits.
  - A capture of channel i clears pending[i] and loads shadow[i] with ch_data[i] on the same edge.
  - A capture together with force_refresh on the same edge leaves pending[i] set.
  - A value that changes while its own chunk is in flight differs from shadow, so pending is set again and a second chunk follows.
  - A change that reverts to the shadow value before arbitration still sends one chunk.
- Arbitration:
  - In IDLE with any pending bit set, select the first pending channel searching upward from rr_ptr+1, wrapping modulo NUM_CHANNELS.
  - Capture that channel: latch type CHUNK_TYPE_BASE+sel and the snapshot of ch_data[sel] into the shift register, update shadow, set rr_ptr = sel, and enter SEND.
- SEND state:
  - tx_valid is high continuously, with byte index k = 0..NB.
  - k = 0 is the type byte (tx_first = 1). k = 1..NB are snapshot bytes, most significant first. tx_last = 1 at k = NB.
  - k advances only on a transfer. While tx_ready is low, tx_byte, tx_first and tx_last are held stable.
  - On the transfer at k = NB: go to HOLDOFF if HOLDOFF_CYCLES > 0, else IDLE. tx_valid is low for at least one cycle between chunks.
- HOLDOFF state:
  - Counts HOLDOFF_CYCLES cycles, then returns to IDLE.
  - Pending bits keep accumulating during holdoff.
- Latency: a new value sampled at edge t sets pending at edge t. If the FSM is IDLE, capture happens at edge t+1 and tx_valid is high after edge t+1.
- Throughput: a chunk of 1+NB bytes takes at least 1+NB cycles with tx_ready held high, plus 1 IDLE cycle and HOLDOFF_CYCLES.
- Only the snapshot taken at capture is sent; changes to ch_data during SEND do not alter the bytes in flight.

Test Plan:
- Defaults, tx_ready=1, ch_data=0, release reset → four chunks in order 02 00 00, 03 00 00, 04 00 00, 05 00 00; pending goes to 0 after the last capture.
- Idle system, set ch2 = 0xBEEF → chunk 04 BE EF with tx_first on 04 and tx_last on EF; tx_valid rises 2 edges after the change.
- During the 04 chunk, drop tx_ready for 5 cycles on byte BE → BE held stable with tx_valid high, no byte dropped or duplicated.
- With rr_ptr = 2, change ch1 and ch3 on the same edge → ch3 (type 05) is sent before ch1 (type 03).
- Change ch0 to 0x1111 and then to 0x2222 while its chunk is in flight → 02 11 11 followed by 02 22 22.
- HOLDOFF_CYCLES = 10, two channels pending → exactly 11 cycles with tx_valid low between the two chunks. Then assert reset on the second payload byte → tx_valid low next cycle, and the post-reset order restarts at type 02.
